dm_port_arbiter: RTL and testbench

- Sequencer and arbiter for the single synchronous data RAM. Shares the RAM between requester 0 (CPU MEM stage) and requester 1 (debug/display readback port).
- Owns the RAM address, write-enable and write-data pins.
- Absorbs the RAM read latency and returns read data with a one-cycle done pulse, so requesters never count cycles themselves.
- Requester 0 has fixed priority, bounded by a starvation guard for requester 1.

---
 rtl/dm_port_arbiter_if.sv | 47 ++++
 rtl/dm_port_arbiter.sv | 110 +++++++++++
 tb/tb_dm_port_arbiter.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_port_arbiter_if.sv
// Requester-side and RAM-side signals of the data-memory port arbiter.
// The slave modport is the arbiter's view; the master modport is the requester/RAM side.
interface dm_port_arbiter_if;
  logic        m0_req;
  logic [3:0]  m0_wen;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic        m0_gnt;
  logic        m0_done;
  logic [31:0] m0_rdata;

  logic        m1_req;
  logic [3:0]  m1_wen;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic        m1_gnt;
  logic        m1_done;
  logic [31:0] m1_rdata;

  logic [31:0] dm_addr;
  logic [3:0]  dm_wen;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;

  logic        busy;
  logic        owner;

  modport slave (
    input  m0_req, m0_wen, m0_addr, m0_wdata,
    output m0_gnt, m0_done, m0_rdata,
    input  m1_req, m1_wen, m1_addr, m1_wdata,
    output m1_gnt, m1_done, m1_rdata,
    output dm_addr, dm_wen, dm_wdata,
    input  dm_rdata,
    output busy, owner
  );

  modport master (
    output m0_req, m0_wen, m0_addr, m0_wdata,
    input  m0_gnt, m0_done, m0_rdata,
    output m1_req, m1_wen, m1_addr, m1_wdata,
    input  m1_gnt, m1_done, m1_rdata,
    input  dm_addr, dm_wen, dm_wdata,
    output dm_rdata,
    input  busy, owner
  );
endinterface

// File: rtl/dm_port_arbiter.sv
// Two-requester sequencer for the synchronous data RAM: fixed priority to port 0 with a
// starvation guard for port 1, and read-latency absorption with a one-cycle done pulse.
//
// state  | meaning
// IDLE   | waiting for a request; arbitration and address/data latch happen here
// ACCESS | RAM address cycle; dm_wen driven, gnt pulse to owner
// RDWAIT | counting out the RAM read latency; read data captured on the last cycle
// DONE   | done pulse to owner
module dm_port_arbiter #(
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 4
) (
  input logic              clk,
  input logic              resetn,
  dm_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT, DONE} state_t;

  state_t     state;
  logic [3:0] wen_lat;
  logic [3:0] starve_cnt;
  logic [2:0] rd_cnt;
  logic       starved;
  logic       any_req;
  logic       pick1;

  assign starved = (starve_cnt == 4'(STARVE_MAX));
  assign any_req = bus.m0_req | bus.m1_req;
  assign pick1   = bus.m1_req & (~bus.m0_req | starved);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      wen_lat      <= '0;
      starve_cnt   <= '0;
      rd_cnt       <= '0;
      bus.dm_addr  <= '0;
      bus.dm_wen   <= '0;
      bus.dm_wdata <= '0;
      bus.m0_gnt   <= 1'b0;
      bus.m1_gnt   <= 1'b0;
      bus.m0_done  <= 1'b0;
      bus.m1_done  <= 1'b0;
      bus.m0_rdata <= '0;
      bus.m1_rdata <= '0;
      bus.busy     <= 1'b0;
      bus.owner    <= 1'b0;
    end else begin
      // pulses and the write strobe default low; each is raised for exactly one state
      bus.m0_gnt  <= 1'b0;
      bus.m1_gnt  <= 1'b0;
      bus.m0_done <= 1'b0;
      bus.m1_done <= 1'b0;
      bus.dm_wen  <= '0;

      case (state)
        IDLE: begin
          if (!bus.m1_req) starve_cnt <= '0;
          if (any_req) begin
            state        <= ACCESS;
            bus.busy     <= 1'b1;
            bus.owner    <= pick1;
            bus.dm_addr  <= pick1 ? bus.m1_addr  : bus.m0_addr;
            bus.dm_wdata <= pick1 ? bus.m1_wdata : bus.m0_wdata;
            bus.dm_wen   <= pick1 ? bus.m1_wen   : bus.m0_wen;
            wen_lat      <= pick1 ? bus.m1_wen   : bus.m0_wen;
            bus.m0_gnt   <= ~pick1;
            bus.m1_gnt   <= pick1;
            if (pick1)
              starve_cnt <= '0;
            else if (bus.m1_req && !starved)
              starve_cnt <= starve_cnt + 4'd1;
          end
        end

        ACCESS: begin
          if (wen_lat != 4'b0000) begin
            state       <= DONE;
            bus.m0_done <= ~bus.owner;
            bus.m1_done <= bus.owner;
          end else begin
            rd_cnt <= 3'(RD_LAT - 1);
            state  <= RDWAIT;
          end
        end

        RDWAIT: begin
          if (rd_cnt == 3'd0) begin
            if (bus.owner) bus.m1_rdata <= bus.dm_rdata;
            else           bus.m0_rdata <= bus.dm_rdata;
            state       <= DONE;
            bus.m0_done <= ~bus.owner;
            bus.m1_done <= bus.owner;
          end else begin
            rd_cnt <= rd_cnt - 3'd1;
          end
        end

        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Scoreboard bench for dm_port_arbiter: a RD_LAT=2 instance for the main scenarios and a
// RD_LAT=1 instance for back-to-back read timing, each with a small RAM model.
module tb_dm_port_arbiter;
  localparam int RD_LAT = 2;

  typedef struct {
    int          port;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gnt_cyc;
    int          done_cyc;
  } sb_t;

  logic clk;
  logic resetn;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   done_cnt = 0;

  sb_t  sb_q[$];
  sb_t  q1[$];
  sb_t  mon_e;
  sb_t  mon1_e;
  logic [31:0] exp_rd0 = '0;
  logic [31:0] exp_rd1 = '0;

  dm_port_arbiter_if bus ();
  dm_port_arbiter_if b1 ();

  dm_port_arbiter #(.RD_LAT(RD_LAT), .STARVE_MAX(4)) u_dut (
    .clk(clk), .resetn(resetn), .bus(bus.slave)
  );

  dm_port_arbiter #(.RD_LAT(1), .STARVE_MAX(4)) u_dut_lat1 (
    .clk(clk), .resetn(resetn), .bus(b1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // RAM models: byte-enable writes, read pipeline of RD_LAT registers
  logic [31:0] mem0 [64];
  logic [31:0] pipe0 [2];
  logic [31:0] mem1 [64];
  logic [31:0] rd1;

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (bus.dm_wen[b]) mem0[bus.dm_addr[7:2]][8*b +: 8] <= bus.dm_wdata[8*b +: 8];
    pipe0[0] <= mem0[bus.dm_addr[7:2]];
    pipe0[1] <= pipe0[0];
    rd1      <= mem1[b1.dm_addr[7:2]];
  end
  assign bus.dm_rdata = pipe0[1];
  assign b1.dm_rdata  = rd1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic gnt_of(input int p);
    return (p != 0) ? bus.m1_gnt : bus.m0_gnt;
  endfunction

  function automatic logic done_of(input int p);
    return (p != 0) ? bus.m1_done : bus.m0_done;
  endfunction

  task automatic drive(input int p, input logic req, input logic [3:0] wen,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (p == 0) begin
      bus.m0_req = req; bus.m0_wen = wen; bus.m0_addr = addr; bus.m0_wdata = wdata;
    end else begin
      bus.m1_req = req; bus.m1_wen = wen; bus.m1_addr = addr; bus.m1_wdata = wdata;
    end
  endtask

  // one complete access on the main instance, starting from an idle arbiter
  task automatic access(input int p, input logic [3:0] wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata);
    sb_t e;
    int  n;
    @(negedge clk);
    e.port = p; e.wen = wen; e.addr = addr; e.wdata = wdata; e.rdata = rdata;
    e.gnt_cyc  = cyc + 1;
    e.done_cyc = cyc + 2 + ((wen == 4'b0000) ? RD_LAT : 0);
    sb_q.push_back(e);
    drive(p, 1'b1, wen, addr, wdata);
    n = 0;
    do begin @(negedge clk); n++; end while (!gnt_of(p) && n < 20);
    chk("gnt_seen", 32'(gnt_of(p)), 32'd1);
    drive(p, 1'b0, 4'b0000, 32'h0, 32'h0);
    n = 0;
    while (!done_of(p) && n < 40) begin @(negedge clk); n++; end
    chk("done_seen", 32'(done_of(p)), 32'd1);
  endtask

  // main-instance monitor: gnt peeks at the scoreboard head, done pops it
  always @(negedge clk) begin
    if (!resetn) begin
      sb_q.delete();
      exp_rd0 = '0;
      exp_rd1 = '0;
    end else begin
      if (bus.m0_gnt || bus.m1_gnt) begin
        if (sb_q.size() == 0) chk("unexp_gnt", 32'(sb_q.size()), 32'd1);
        else begin
          mon_e = sb_q[0];
          chk("gnt_port", 32'({bus.m1_gnt, bus.m0_gnt}), (mon_e.port != 0) ? 32'd2 : 32'd1);
          chk("gnt_owner", 32'(bus.owner), 32'(mon_e.port));
          chk("gnt_busy", 32'(bus.busy), 32'd1);
          chk("dm_wen", 32'(bus.dm_wen), 32'(mon_e.wen));
          chk("dm_addr", bus.dm_addr, mon_e.addr);
          chk("dm_wdata", bus.dm_wdata, mon_e.wdata);
          if (mon_e.gnt_cyc >= 0) chk("gnt_cyc", 32'(cyc), 32'(mon_e.gnt_cyc));
        end
      end else begin
        chk("dm_wen_idle", 32'(bus.dm_wen), 32'd0);
      end
      if (bus.m0_done || bus.m1_done) begin
        if (sb_q.size() == 0) chk("unexp_done", 32'(sb_q.size()), 32'd1);
        else begin
          mon_e = sb_q.pop_front();
          chk("done_port", 32'({bus.m1_done, bus.m0_done}), (mon_e.port != 0) ? 32'd2 : 32'd1);
          chk("done_busy", 32'(bus.busy), 32'd1);
          if (mon_e.done_cyc >= 0) chk("done_cyc", 32'(cyc), 32'(mon_e.done_cyc));
          if (mon_e.wen == 4'b0000) begin
            if (mon_e.port != 0) exp_rd1 = mon_e.rdata;
            else                 exp_rd0 = mon_e.rdata;
          end
          chk("m0_rdata", bus.m0_rdata, exp_rd0);
          chk("m1_rdata", bus.m1_rdata, exp_rd1);
          done_cnt++;
        end
      end
    end
  end

  // RD_LAT=1 instance monitor
  always @(negedge clk) begin
    if (!resetn) q1.delete();
    else if (b1.m0_done || b1.m1_done) begin
      if (q1.size() == 0) chk("l1_unexp_done", 32'(q1.size()), 32'd1);
      else begin
        mon1_e = q1.pop_front();
        chk("l1_done_port", 32'({b1.m1_done, b1.m0_done}), 32'd1);
        chk("l1_done_cyc", 32'(cyc), 32'(mon1_e.done_cyc));
        chk("l1_rdata", b1.m0_rdata, mon1_e.rdata);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    int   base;
    int   c0;
    int   starve_pat[10];
    sb_t  e;

    starve_pat = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    for (int i = 0; i < 64; i++) begin
      mem0[i] = '0;
      mem1[i] = 32'hA500_0000 | 32'(i);
    end
    resetn = 1'b0;
    drive(0, 1'b0, 4'b0000, 32'h0, 32'h0);
    drive(1, 1'b0, 4'b0000, 32'h0, 32'h0);
    b1.m0_req = 1'b0; b1.m0_wen = '0; b1.m0_addr = '0; b1.m0_wdata = '0;
    b1.m1_req = 1'b0; b1.m1_wen = '0; b1.m1_addr = '0; b1.m1_wdata = '0;

    repeat (3) @(negedge clk);
    chk("rst_ctl", 32'({bus.m0_gnt, bus.m1_gnt, bus.m0_done, bus.m1_done, bus.busy, bus.owner, bus.dm_wen}), 32'd0);
    chk("rst_dm_addr", bus.dm_addr, 32'h0);
    chk("rst_dm_wdata", bus.dm_wdata, 32'h0);
    chk("rst_rdata", bus.m0_rdata | bus.m1_rdata, 32'h0);
    resetn = 1'b1;
    @(negedge clk);

    // m0 full-word write, then busy must drop the cycle after done
    access(0, 4'b1111, 32'h10, 32'hDEAD_BEEF, 32'h0);
    @(negedge clk);
    chk("busy_after_wr", 32'(bus.busy), 32'd0);

    // m0 read-back, m1 rdata untouched
    access(0, 4'b0000, 32'h10, 32'h0, 32'hDEAD_BEEF);
    chk("m1_rdata_still0", bus.m1_rdata, 32'h0);

    // m1 single-byte write, then read the containing word on m1
    access(1, 4'b0100, 32'h22, 32'h00AB_0000, 32'h0);
    access(1, 4'b0000, 32'h20, 32'h0, 32'h00AB_0000);
    chk("m0_rdata_hold", bus.m0_rdata, 32'hDEAD_BEEF);

    // both requesting continuously: starvation guard grant order
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      e.port = starve_pat[i];
      e.wen = 4'b1111;
      e.addr = (starve_pat[i] != 0) ? 32'h44 : 32'h40;
      e.wdata = (starve_pat[i] != 0) ? 32'h2222_0000 : 32'h1111_0000;
      e.rdata = '0;
      e.gnt_cyc = -1;
      e.done_cyc = -1;
      sb_q.push_back(e);
    end
    base = done_cnt;
    drive(0, 1'b1, 4'b1111, 32'h40, 32'h1111_0000);
    drive(1, 1'b1, 4'b1111, 32'h44, 32'h2222_0000);
    n = 0;
    while (done_cnt < base + 10 && n < 200) begin @(negedge clk); #1; n++; end
    chk("starve_dones", 32'(done_cnt), 32'(base + 10));
    drive(0, 1'b0, 4'b0000, 32'h0, 32'h0);
    drive(1, 1'b0, 4'b0000, 32'h0, 32'h0);
    repeat (3) @(negedge clk);

    // reset during RDWAIT of an m0 read
    @(negedge clk);
    e.port = 0; e.wen = 4'b0000; e.addr = 32'h10; e.wdata = 32'h0; e.rdata = 32'hDEAD_BEEF;
    e.gnt_cyc = cyc + 1; e.done_cyc = cyc + 2 + RD_LAT;
    sb_q.push_back(e);
    drive(0, 1'b1, 4'b0000, 32'h10, 32'h0);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.m0_gnt && n < 20);
    chk("rst_rd_gnt_seen", 32'(bus.m0_gnt), 32'd1);
    drive(0, 1'b0, 4'b0000, 32'h0, 32'h0);
    @(negedge clk);
    chk("pre_rst_busy", 32'(bus.busy), 32'd1);
    resetn = 1'b0;
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_dm_wen", 32'(bus.dm_wen), 32'd0);
    chk("rst_dm_addr_mid", bus.dm_addr, 32'h0);
    chk("rst_m0_rdata", bus.m0_rdata, 32'h0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    base = done_cnt;
    repeat (8) @(negedge clk);
    chk("no_done_after_rst", 32'(done_cnt), 32'(base));
    chk("m0_rdata_after_rst", bus.m0_rdata, 32'h0);
    access(0, 4'b0000, 32'h10, 32'h0, 32'hDEAD_BEEF);

    // RD_LAT=1 instance: back-to-back reads with req held
    @(negedge clk);
    c0 = cyc;
    e.port = 0; e.wen = 4'b0000; e.addr = 32'h0; e.wdata = 32'h0; e.gnt_cyc = -1;
    e.rdata = 32'hA500_0000; e.done_cyc = c0 + 3;
    q1.push_back(e);
    e.addr = 32'h4; e.rdata = 32'hA500_0001; e.done_cyc = c0 + 7;
    q1.push_back(e);
    b1.m0_req = 1'b1; b1.m0_wen = 4'b0000; b1.m0_addr = 32'h0;
    n = 0;
    do begin @(negedge clk); n++; end while (!b1.m0_gnt && n < 20);
    chk("l1_gnt1_seen", 32'(b1.m0_gnt), 32'd1);
    b1.m0_addr = 32'h4;
    n = 0;
    do begin @(negedge clk); n++; end while (!b1.m0_gnt && n < 20);
    chk("l1_gnt2_seen", 32'(b1.m0_gnt), 32'd1);
    chk("l1_gnt2_cyc", 32'(cyc), 32'(c0 + 5));
    chk("l1_rdata_hold", b1.m0_rdata, 32'hA500_0000);
    b1.m0_req = 1'b0;
    n = 0;
    while (q1.size() > 0 && n < 20) begin @(negedge clk); #1; n++; end
    chk("l1_q_drained", 32'(q1.size()), 32'd0);

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
